uart_rx_fifo: RTL and testbench

// Receive buffer between uart_rx and the peripheral read mux at the UART register address.

---
 rtl/uart_rx_fifo.sv | 110 +++++++++++
 tb/tb_uart_rx_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between uart_rx and the CPU data register.
// Captures one byte per valid/read handshake into a DEPTH-entry FIFO, exposes
// the head byte and level/full/empty status, and raises a level-threshold irq.
module uart_rx_fifo #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 8,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ack,
  input  logic              pop,
  input  logic              flush,
  input  logic              thresh_wr,
  input  logic [PTR_W:0]    thresh_in,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W:0]    level,
  output logic              empty,
  output logic              full,
  output logic              irq
);

  localparam logic [PTR_W:0] L_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,  // ready to capture the next byte
    S_ACK,   // rx_ack is high this cycle
    S_WAIT   // waiting for uart_rx to drop valid
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_rx_ack;
  logic              w_capture;
  logic              w_pop;
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic [PTR_W:0]    w_wr_ptr_next;
  logic [PTR_W:0]    r_thresh;
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Capture FSM next-state and capture decision.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid && !full) begin
          w_capture    = 1'b1;
          w_state_next = S_ACK;
        end
      end
      S_ACK:   w_state_next = S_WAIT;
      S_WAIT:  if (!rx_valid) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture FSM state register and registered read strobe to uart_rx.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      r_state  <= S_IDLE;
      r_rx_ack <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rx_ack <= w_capture;
    end
  end

  assign w_pop         = pop && !empty;
  assign w_wr_ptr_next = w_capture ? r_wr_ptr + L_ONE : r_wr_ptr;

  // Pointer update; flush lands after a same-edge write so the FIFO ends empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      if (flush)      r_rd_ptr <= w_wr_ptr_next;
      else if (w_pop) r_rd_ptr <= r_rd_ptr + L_ONE;
    end
  end

  // Byte storage written on capture.
  // NOTE: the storage array has no reset; rd_data is gated by empty, so stale entries never show.
  always_ff @(posedge clk) begin
    if (w_capture) r_mem[r_wr_ptr[PTR_W-1:0]] <= rx_data;
  end

  // Interrupt threshold register, clamped to DEPTH on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_thresh <= L_ONE;
    else if (thresh_wr) r_thresh <= (thresh_in > L_DEPTH) ? L_DEPTH : thresh_in;
  end

  assign level   = r_wr_ptr - r_rd_ptr;
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
  assign irq     = (r_thresh != '0) && (level >= r_thresh);
  assign rx_ack  = r_rx_ack;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives uart_rx_fifo with a uart_rx handshake model plus
// random CPU pops/flushes/threshold writes, and compares every cycle against a
// queue-based model of the receive buffer.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ack;
  logic              pop;
  logic              flush;
  logic              thresh_wr;
  logic [PTR_W:0]    thresh_in;
  logic [DATA_W-1:0] rd_data;
  logic [PTR_W:0]    level;
  logic              empty;
  logic              full;
  logic              irq;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ack(rx_ack),
    .pop(pop), .flush(flush),
    .thresh_wr(thresh_wr), .thresh_in(thresh_in),
    .rd_data(rd_data), .level(level), .empty(empty), .full(full), .irq(irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: stored bytes, threshold, and handshake obligations.
  logic [7:0] m_q[$];
  int         m_thresh;
  bit         m_ack;         // a byte was captured last edge, so rx_ack is due now
  bit         m_await_drop;  // acked; no capture until uart_rx drops valid

  // uart_rx side: bytes waiting to be offered, and the ack seen before the edge.
  logic [7:0] src[$];
  logic       ack_pre;
  int         ack_count = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_thresh     = 1;
    m_ack        = 1'b0;
    m_await_drop = 1'b0;
  endfunction

  // Apply one clock edge to the model using the inputs the DUT saw at that edge.
  function automatic void model_edge();
    bit cap;
    bit pp;
    if (rst) begin
      model_reset();
      return;
    end
    cap          = !m_ack && !m_await_drop && rx_valid && (m_q.size() < DEPTH);
    pp           = pop && (m_q.size() > 0);
    m_await_drop = m_ack || (m_await_drop && rx_valid);
    m_ack        = cap;
    if (pp)  void'(m_q.pop_front());
    if (cap) m_q.push_back(rx_data);
    if (flush) m_q.delete();
    if (thresh_wr) m_thresh = (int'(thresh_in) > DEPTH) ? DEPTH : int'(thresh_in);
  endfunction

  function automatic void compare();
    check("rx_ack",  32'(rx_ack), 32'(m_ack));
    check("level",   32'(level),  32'(m_q.size()));
    check("empty",   32'(empty),  32'(m_q.size() == 0));
    check("full",    32'(full),   32'(m_q.size() == DEPTH));
    check("rd_data", 32'(rd_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    check("irq",     32'(irq),    32'(m_thresh != 0 && m_q.size() >= m_thresh));
  endfunction

  // One clock cycle: edge, model update, compare, then uart_rx drives its outputs.
  task automatic step();
    @(negedge clk);
    ack_pre = rx_ack;
    @(posedge clk);
    model_edge();
    #1;
    compare();
    if (rx_ack) ack_count++;
    if (ack_pre) begin
      void'(src.pop_front());
      rx_valid = 1'b0;
    end else if (src.size() > 0) begin
      rx_valid = 1'b1;
      rx_data  = src[0];
    end else begin
      rx_valid = 1'b0;
    end
  endtask

  task automatic settle();
    int budget = 300;
    while ((src.size() > 0 || m_ack || m_await_drop) && budget > 0) begin
      step();
      budget--;
    end
    check("settle_budget", 32'(budget > 0), 32'd1);
  endtask

  // Advance until the next edge is one on which the DUT must capture.
  task automatic wait_capture();
    int budget = 50;
    while (!(!m_ack && !m_await_drop && rx_valid && m_q.size() < DEPTH) && budget > 0) begin
      step();
      budget--;
    end
    check("capture_budget", 32'(budget > 0), 32'd1);
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic write_thresh(input logic [PTR_W:0] v);
    thresh_wr = 1'b1;
    thresh_in = v;
    step();
    thresh_wr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; pop = 1'b0; flush = 1'b0;
    thresh_wr = 1'b0; thresh_in = '0;
    model_reset();
    #1;
    check("rst_rx_ack", 32'(rx_ack), 32'd0);
    check("rst_empty",  32'(empty),  32'd1);
    check("rst_level",  32'(level),  32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Three bytes through the handshake, then popped in order.
    base = ack_count;
    src.push_back(8'h41); src.push_back(8'h42); src.push_back(8'h43);
    settle();
    check("t2_acks",  32'(ack_count - base), 32'd3);
    check("t2_level", 32'(level),   32'd3);
    check("t2_head",  32'(rd_data), 32'h41);
    do_pop(); check("t2_pop1", 32'(rd_data), 32'h42);
    do_pop(); check("t2_pop2", 32'(rd_data), 32'h43);
    do_pop(); check("t2_empty", 32'(empty), 32'd1);

    // Fill to full with a ninth byte held on rx_valid.
    for (int i = 0; i < 9; i++) src.push_back(8'(8'h10 + i));
    n = 0;
    while (m_q.size() < DEPTH && n < 100) begin step(); n++; end
    check("t3_full", 32'(full), 32'd1);
    base = ack_count;
    repeat (20) step();
    check("t3_no_ack", 32'(ack_count - base), 32'd0);
    check("t3_level_held", 32'(level), 32'd8);
    do_pop();
    n = 0;
    while (level != 4'd8 && n < 3) begin step(); n++; end
    check("t3_refill", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("t3_order", 32'(rd_data), 32'(8'h11 + i));
      do_pop();
    end
    settle();
    check("t3_drained", 32'(empty), 32'd1);

    // Capture and pop on the same edge at level 4.
    for (int i = 0; i < 4; i++) src.push_back(8'(8'h20 + i));
    settle();
    check("t4_level_pre", 32'(level), 32'd4);
    src.push_back(8'h99);
    wait_capture();
    pop = 1'b1; step(); pop = 1'b0;
    check("t4_level", 32'(level),   32'd4);
    check("t4_head",  32'(rd_data), 32'h21);
    settle();
    do_flush();

    // Threshold interrupt.
    write_thresh(4'd2);
    src.push_back(8'h31); settle();
    check("t5_irq_l1", 32'(irq), 32'd0);
    src.push_back(8'h32); settle();
    check("t5_irq_l2", 32'(irq), 32'd1);
    do_pop();
    check("t5_irq_pop", 32'(irq), 32'd0);
    for (int i = 0; i < 7; i++) src.push_back(8'(8'h70 + i));
    settle();
    check("t5_level8", 32'(level), 32'd8);
    write_thresh(4'd0);
    check("t5_irq_off", 32'(irq), 32'd0);
    write_thresh(4'd15);
    check("t5_clamp_l8", 32'(irq), 32'd1);
    do_pop();
    check("t5_clamp_l7", 32'(irq), 32'd0);
    do_flush();

    // Flush on the same edge as a capture.
    for (int i = 0; i < 5; i++) src.push_back(8'(8'h60 + i));
    settle();
    check("t6_level_pre", 32'(level), 32'd5);
    src.push_back(8'h55);
    wait_capture();
    base = ack_count;
    flush = 1'b1; step(); flush = 1'b0;
    check("t6_level", 32'(level), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    repeat (3) step();
    check("t6_ack_once", 32'(ack_count - base), 32'd1);

    // Random traffic, alternating light and heavy CPU drain.
    for (int c = 0; c < 3000; c++) begin
      int pop_pct;
      pop_pct = ((c / 500) % 2 == 0) ? 8 : 50;
      if (src.size() < 3 && $urandom_range(0, 2) == 0) src.push_back(8'($urandom));
      pop       = ($urandom_range(0, 99) < pop_pct);
      flush     = ($urandom_range(0, 199) < 3);
      thresh_wr = ($urandom_range(0, 99) < 3);
      thresh_in = (PTR_W+1)'($urandom);
      step();
    end
    pop = 1'b0; flush = 1'b0; thresh_wr = 1'b0;

    // Asynchronous reset while rx_ack is high.
    for (int i = 0; i < 4; i++) src.push_back(8'(8'hA0 + i));
    n = 0;
    while (!(rx_ack && m_q.size() > 1) && n < 100) begin step(); n++; end
    check("t1_found_ack", 32'(rx_ack), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t1_rx_ack",  32'(rx_ack),  32'd0);
    check("t1_level",   32'(level),   32'd0);
    check("t1_empty",   32'(empty),   32'd1);
    check("t1_irq",     32'(irq),     32'd0);
    check("t1_rd_data", 32'(rd_data), 32'h00);
    step(); step();
    rst = 1'b0;
    settle();
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
